// File: rtl/obc_shift_accumulator.sv
// obc_shift_accumulator: MSB-first shift-and-add accumulator behind one OBC
// DFT ROM stage. It steps the ROM slice index, accumulates the signed ROM
// partial sums, adds the OBC offset, halves the total, and holds the result
// on a valid/ready output until the consumer accepts it.
// Build option: define OBC_ACC_SAT_EN to saturate the result to the signed
// OUT_W range. Without it, the result keeps only the low OUT_W bits (wrap).
module obc_shift_accumulator #(
    parameter int                      DATA_W = 16,
    parameter int                      ROM_W  = 32,
    parameter int                      ACC_W  = 48,
    parameter int                      OUT_W  = 32,
    parameter logic signed [ACC_W-1:0] OFFSET = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [ROM_W-1:0]      romout,
    output logic [$clog2(DATA_W)-1:0]    slice_idx,
    output logic                         m,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      result
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         slice_q, slice_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  result_q, result_d;

    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  sum_off;
    logic signed [ACC_W-1:0]  sum_half;
    logic signed [OUT_W-1:0]  fit_val;

    // Shift-and-add datapath, offset, halving, and final fit to OUT_W bits
    always_comb begin
        acc_next = (acc_q <<< 1) + {{(ACC_W-ROM_W){romout[ROM_W-1]}}, romout};
        sum_off  = acc_next + OFFSET;
        sum_half = sum_off >>> 1;
`ifdef OBC_ACC_SAT_EN
        if (sum_half > SAT_MAX) begin
            fit_val = SAT_MAX[OUT_W-1:0];
        end else if (sum_half < SAT_MIN) begin
            fit_val = SAT_MIN[OUT_W-1:0];
        end else begin
            fit_val = OUT_W'(sum_half);
        end
`else
        fit_val = OUT_W'(sum_half);
`endif
    end

    // Next-state logic for the FSM, slice counter, accumulator and result
    always_comb begin
        state_d  = state_q;
        slice_d  = slice_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    slice_d = IDX_MAX;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                acc_d   = acc_next;
                slice_d = slice_q - 1'b1;
                if (slice_q == '0) begin
                    state_d  = DONE;
                    slice_d  = '0;
                    result_d = fit_val;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        slice_d = IDX_MAX;
                        acc_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                slice_d = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            slice_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            slice_q  <= slice_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Outputs decoded from registered state; slice_q is 0 outside ACCUM
    always_comb begin
        slice_idx = slice_q;
        m         = (state_q == ACCUM) && (slice_q == IDX_MAX);
        busy      = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        result    = result_q;
    end

endmodule

// File: doc/obc_shift_accumulator.md
# obc_shift_accumulator

Sequential back end of one offset-binary-coded (OBC) DFT output term. It steps the bit-slice index seen by the combinational OBC ROM stage and drives the ROM's MSB flag `m`. It accumulates the signed 32-bit ROM partial sums MSB-first with shift-and-add, then applies the OBC offset and the final halving. The finished coefficient is presented on a valid/ready output; one instance sits behind each real or imaginary ROM stage of the 16-point DFT.

## Interface
- `DATA_W`, 16: bits per input sample, which is also the number of slices per transform.
- `ROM_W`, 32: width of the ROM partial sum (signed two's complement).
- `ACC_W`, 48: accumulator width (signed); must be ≥ ROM_W + DATA_W.
- `OUT_W`, 32: result width (signed).
- `OFFSET`, 0: signed ACC_W-bit OBC offset constant, added once after the last slice.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transform; sampled only in IDLE, or in DONE together with `out_ready`.
- `romout`  in  ROM_W  signed ROM partial sum for the current `slice_idx`; combinational from the ROM stage.
- `slice_idx`  out  clog2(DATA_W)  bit position the upstream sample register presents to the ROM.
- `m`  out  1  ROM MSB flag; high only while `slice_idx == DATA_W-1` in ACCUM.
- `busy`  out  1  high in ACCUM.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  OUT_W  signed DFT coefficient.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset forces IDLE.
- IDLE → ACCUM on `start`. Load `slice_idx = DATA_W-1` and clear the accumulator.
- ACCUM, every cycle:
  - `acc_next = (acc <<< 1) + sext(romout)`, computed in ACC_W bits.
  - On the first slice, `acc` is taken as 0.
  - `slice_idx` decrements by 1.
- ACCUM → DONE on the cycle with `slice_idx == 0`.
  - On that edge, register `result = fit((acc_next + OFFSET) >>> 1)`, where `>>>` is an arithmetic shift in ACC_W bits.
  - `fit()` is defined under Configuration.
- DONE: hold `out_valid = 1` and keep `result` stable until `out_ready`.
  - `out_ready` with `start` low → IDLE.
  - `out_ready` with `start` high → ACCUM directly, so back-to-back transforms need no IDLE bubble.
- `start` in ACCUM is ignored. `start` in DONE without `out_ready` is ignored.
- Accumulator overflow wraps modulo 2^ACC_W and is not flagged.
- `slice_idx` and `m` are 0 outside ACCUM.

## Timing
- Reset values: `slice_idx = 0`, `m = 0`, `busy = 0`, `out_valid = 0`, `result = 0`, accumulator 0, state IDLE.
- `start` sampled high on edge E0:
  - ACCUM covers cycles E0+1 … E0+DATA_W.
  - `slice_idx` steps DATA_W-1 … 0 across those cycles.
  - `m` is high during cycle E0+1 only.
- `out_valid` rises after edge E0+DATA_W. Latency from `start` to `out_valid` is DATA_W+1 edges.
- Throughput: one transform per DATA_W+1 cycles with `out_ready` held high.
- `romout` must be settled within the same cycle as its `slice_idx`; there is no input register.
- An `rst` assertion at any point, including mid-ACCUM or in DONE, aborts immediately to the reset values. The partial result is discarded.

## Configuration
- `OBC_ACC_SAT_EN` defined:
  - `fit()` saturates to the signed OUT_W range, clamping to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- `OBC_ACC_SAT_EN` undefined:
  - `fit()` truncates to the low OUT_W bits (wrap).
- With the default OUT_W and ACC_W the two builds differ only on overflow.

## Test plan
- Basic transform: DATA_W=4, OFFSET=1, `romout = 1` on all slices, `start` pulse, `out_ready = 1` → `slice_idx` sequence 3,2,1,0; `m` high on the first cycle only; accumulator 1,3,7,15; `result = 8`; `out_valid` 5 edges after `start`.
- Negative sums: DATA_W=4, OFFSET=-1, `romout = 0xFFFFFFFF` on all slices → `result = -8` (0xFFFFFFF8).
- Backpressure and back-to-back: hold `out_ready = 0` for 3 cycles in DONE → `result` and `out_valid` stable. Then assert `out_ready` and `start` together → `out_valid` drops, `busy` rises on the next cycle, and the second result arrives 5 edges later.
- Saturation: DATA_W=4, OUT_W=8, OFFSET=0, `romout = 200` on all slices → `result = 127` with `OBC_ACC_SAT_EN`; `result = 0xDC` without it.
- Reset mid-operation: assert `rst` during the 2nd ACCUM cycle → all outputs return to zero immediately. A new `start` after release produces a correct, uncorrupted result.
- Ignored `start`: pulse `start` during ACCUM → no restart; `slice_idx` sequence and `result` unchanged.
